// File: rtl/scadere_pkg.sv
// rtl/scadere_pkg.sv - shared widths, per-stage pipeline record and slice subtract helper
package scadere_pkg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int SLICE  = WIDTH / STAGES;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] res_acc;
    logic             bin;
  } stage_t;

  // Result bit SLICE is the borrow out of this slice.
  function automatic logic [SLICE:0] slice_sub(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             bin
  );
    slice_sub = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  endfunction

endpackage

// File: rtl/scadere_stage.sv
// rtl/scadere_stage.sv - one slice subtract with its elastic pipeline register
module scadere_stage
  import scadere_pkg::*;
#(
  parameter int K = 0
) (
  input  logic   clk,
  input  logic   clr_n,
  input  logic   i_flush,
  input  logic   i_adv,
  input  stage_t i_prev,
  output stage_t o_stage
);

  stage_t           r_q;
  logic [SLICE:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_load;

  assign w_diff = slice_sub(i_prev.a_rem[K*SLICE +: SLICE],
                            i_prev.b_rem[K*SLICE +: SLICE],
                            i_prev.bin);

  // Data only moves when a real operation arrives, so bubbles leave the register untouched.
  assign w_load = i_adv && i_prev.valid;

  always_comb begin
    w_res = i_prev.res_acc;
    w_res[K*SLICE +: SLICE] = w_diff[SLICE-1:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= '0;
    end else begin
      if (i_flush) begin
        r_q.valid <= 1'b0;
      end else if (i_adv) begin
        r_q.valid <= i_prev.valid;
      end
      if (w_load) begin
        r_q.a_rem   <= i_prev.a_rem;
        r_q.b_rem   <= i_prev.b_rem;
        r_q.res_acc <= w_res;
        r_q.bin     <= w_diff[SLICE];
      end
    end
  end

  assign o_stage = r_q;

endmodule

// File: rtl/scadere_pipe.sv
// rtl/scadere_pipe.sv - pipelined WIDTH-bit subtractor with borrow flag and valid/ready handshake
module scadere_pipe
  import scadere_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             borrow
);

  stage_t        w_in;
  stage_t        w_q [STAGES];
  logic [STAGES:0] w_adv;

  always_comb begin
    w_in         = '0;
    w_in.valid   = in_valid;
    w_in.a_rem   = in1;
    w_in.b_rem   = in2;
  end

  // A stage may advance if it is empty or the stage after it advances.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !w_q[k].valid || w_adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      scadere_stage #(.K(k)) u_stage (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_flush (flush),
        .i_adv   (w_adv[k]),
        .i_prev  (w_in),
        .o_stage (w_q[k])
      );
    end else begin : g_rest
      scadere_stage #(.K(k)) u_stage (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_flush (flush),
        .i_adv   (w_adv[k]),
        .i_prev  (w_q[k-1]),
        .o_stage (w_q[k])
      );
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_q[STAGES-1].valid;
  assign out1      = w_q[STAGES-1].res_acc;
  assign borrow    = w_q[STAGES-1].bin;

endmodule

// File: tb/tb_scadere_pipe.sv
// tb/tb_scadere_pipe.sv - scoreboard bench for scadere_pipe
module tb_scadere_pipe;

  logic        clk;
  logic        clr_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out1;
  logic        borrow;

  logic [32:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  scadere_pipe dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .borrow    (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    ref_sub = {1'b0, a} - {1'b0, b};
  endfunction

  task automatic test_reset();
    clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out1 !== 32'h0) begin errors++; $display("FAIL reset_out1 got %h exp 00000000", out1); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    logic [32:0] e;
    @(negedge clk);
    in_valid = 1'b1; in1 = 32'd10; in2 = 32'd3; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
    exp_q.push_back(ref_sub(in1, in2));
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
    checks++;
    if (out1 !== 32'h7 || borrow !== 1'b0)
      begin errors++; $display("FAIL basic_value got %b_%h exp 0_00000007", borrow, out1); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({borrow, out1} !== e)
        begin errors++; $display("FAIL basic_model got %b_%h exp %b_%h", borrow, out1, e[32], e[31:0]); end
    end
  endtask

  task automatic test_arith_edges();
    logic [31:0] av [3] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] bv [3] = '{32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF};
    logic [32:0] ev [3] = '{{1'b1, 32'hFFFF_FFFF}, {1'b0, 32'h0000_FFFF}, {1'b0, 32'h0000_0001}};
    logic [32:0] e;
    int fed = 0;
    int got = 0;
    int cyc = 0;
    while ((fed < 3 || got < 3) && cyc < 40) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (fed < 3) begin in_valid = 1'b1; in1 = av[fed]; in2 = bv[fed]; end
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ev[fed]); fed++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL edge_extra got %b_%h exp none", borrow, out1); end
        else begin
          e = exp_q.pop_front();
          if ({borrow, out1} !== e)
            begin errors++; $display("FAIL edge_value got %b_%h exp %b_%h", borrow, out1, e[32], e[31:0]); end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL edge_count got %0d exp 3", got); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    int fed = 0;
    int got = 0;
    int cyc = 0;
    int first = 0;
    int last = 0;
    int stalls = 0;
    while ((fed < 8 || got < 8) && cyc < 60) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (fed < 8) begin
        in_valid = 1'b1; in1 = $urandom; in2 = (fed == 3) ? in1 : $urandom;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(in1, in2)); fed++; end
      if (out_valid && out_ready) begin
        if (got == 0) first = cyc;
        last = cyc;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got %b_%h exp none", borrow, out1); end
        else begin
          e = exp_q.pop_front();
          if ({borrow, out1} !== e)
            begin errors++; $display("FAIL b2b_value got %b_%h exp %b_%h", borrow, out1, e[32], e[31:0]); end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", got); end
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL b2b_in_ready stalls %0d exp 0", stalls); end
    checks++;
    if (last - first !== 7) begin errors++; $display("FAIL b2b_spacing got %0d exp 7", last - first); end
  endtask

  task automatic test_stall();
    logic [32:0] e;
    logic [32:0] held = '0;
    logic        have_held = 1'b0;
    int fed = 0;
    int got = 0;
    int cyc = 0;
    int unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (fed < 6) begin in_valid = 1'b1; in1 = $urandom; in2 = $urandom; end
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(in1, in2)); fed++; end
      if (out_valid) begin
        if (!have_held) begin held = {borrow, out1}; have_held = 1'b1; end
        else if ({borrow, out1} !== held) unstable++;
      end
    end
    checks++;
    if (fed !== 4) begin errors++; $display("FAIL stall_accepts got %0d exp 4", fed); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    checks++;
    if (unstable !== 0 || !have_held)
      begin errors++; $display("FAIL stall_hold changes %0d seen %b exp 0 1", unstable, have_held); end
    while ((fed < 6 || got < 6) && cyc < 40) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (fed < 6) begin in_valid = 1'b1; in1 = $urandom; in2 = $urandom; end
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(in1, in2)); fed++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra got %b_%h exp none", borrow, out1); end
        else begin
          e = exp_q.pop_front();
          if ({borrow, out1} !== e)
            begin errors++; $display("FAIL stall_value got %b_%h exp %b_%h", borrow, out1, e[32], e[31:0]); end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 6 || exp_q.size() != 0)
      begin errors++; $display("FAIL stall_drain got %0d left %0d exp 6 0", got, exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = 32'h1234_0000 + c; in2 = 32'h0000_1111;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_precond got %b exp 1", out_valid); end
    clr_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out1 !== 32'h0 || borrow !== 1'b0)
      begin errors++; $display("FAIL rstmid_clear got %b %b_%h exp 0 0_00000000", out_valid, borrow, out1); end
    @(negedge clk);
    clr_n = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_stale got %0d exp 0", seen); end
  endtask

  task automatic test_flush();
    logic [32:0] e;
    int seen = 0;
    int got = 0;
    int fed = 0;
    int cyc = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = 32'd100 + c; in2 = 32'd1;
    end
    @(negedge clk);
    in_valid = 1'b1; in1 = 32'd55; in2 = 32'd5; flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_out_valid got %0d exp 0", seen); end
    while ((fed < 1 || got < 1) && cyc < 20) begin
      @(negedge clk);
      if (fed < 1) begin in_valid = 1'b1; in1 = 32'h0000_00FF; in2 = 32'h0000_0100; end
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back({1'b1, 32'hFFFF_FFFF}); fed++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL flush_extra got %b_%h exp none", borrow, out1); end
        else begin
          e = exp_q.pop_front();
          if ({borrow, out1} !== e)
            begin errors++; $display("FAIL flush_after got %b_%h exp %b_%h", borrow, out1, e[32], e[31:0]); end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 1) begin errors++; $display("FAIL flush_after_count got %0d exp 1", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith_edges();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
